pia8255_gen: RTL
================

PIA8255_GEN -- requirements
Module: pia8255_gen

Interface
REQ-001 The block SHALL have parameter RESET_CW, default 8'h9B, giving the control word loaded at reset (9B = mode 0, all ports input).
REQ-002 The block SHALL have parameter PC_RESET, default 8'h00, giving the port C output latch value at reset.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port cs, input, 1 bit: chip select.
REQ-006 The block SHALL have port rnw, input, 1 bit: 1 = read, 0 = write.
REQ-007 The block SHALL have port addr, input, 2 bits: 0 = PA, 1 = PB, 2 = PC, 3 = control.
REQ-008 The block SHALL have port din, input, 8 bits: CPU write data.
REQ-009 The block SHALL have port dout, output, 8 bits: CPU read data, combinational.
REQ-010 The block SHALL have ports pa_i, pb_i and pc_i, inputs, 8 bits each: port pin inputs.
REQ-011 The block SHALL have ports pa_o, pb_o and pc_o, outputs, 8 bits each: port output latches.
REQ-012 The block SHALL have ports pa_oe, pb_oe and pc_oe, outputs, 8 bits each: per-bit output enables, 1 = drive.
REQ-013 The block SHALL have port irq, output, 1 bit: INTR_A | INTR_B.

Function
REQ-014 A write SHALL be cs & !rnw at a clk edge; registers update at that edge, visible on outputs the same cycle after the edge.
REQ-015 A write to addr 0/1/2 SHALL load the PA/PB/PC output latch with din, regardless of direction.
REQ-016 A write to addr 3 with din[7]=1 SHALL load the control word and clear pa_o, pb_o and pc_o to 0.
REQ-017 A write to addr 3 with din[7]=0 SHALL set pc_o[din[3:1]] to din[0]; the control word is unchanged.
REQ-018 Direction SHALL follow control bits: cw[4] PA in, cw[1] PB in, cw[3] PC[7:4] in, cw[0] PC[3:0] in; 1 = input (oe=0), 0 = output (oe=1).
REQ-019 Reads SHALL return the output latch for bits configured as output and the pin (pa_i/pb_i/pc_i) for bits configured as input; PC is mixed per nibble.
REQ-020 Reads of addr 3 SHALL return 8'h00.
REQ-021 irq SHALL be 0 whenever PIA_MODE1_EN is absent.

Reset
REQ-022 reset_n=0 SHALL set asynchronously: cw=RESET_CW, pa_o=pb_o=0, pc_o=PC_RESET, all internal handshake flags=0, irq=0.
REQ-023 Reset asserted mid-handshake SHALL abandon the handshake; after release the block behaves as freshly reset.
REQ-024 The STB history registers SHALL reset to 1 (idle high), so release with STB held low does not latch data.

Configuration
REQ-025 Macro PIA_MODE1_EN SHALL enable the strobed-input (mode 1) feature; without it, cw[6:5] and cw[2] are stored but ignored and all ports operate in mode 0.
REQ-026 With PIA_MODE1_EN, group A SHALL be in mode 1 iff cw[6:5]=01 and cw[4]=1; group B iff cw[2]=1 and cw[1]=1; other combinations run mode 0.
REQ-027 Mode 1 A SHALL use these pins: pc_i[4]=STB_A_n; pc_o[5]=IBF_A; pc_o[3]=INTR_A; these bits are forced to oe=0/1/1 regardless of cw[3]/cw[0].
REQ-028 Mode 1 B SHALL use these pins: pc_i[2]=STB_B_n; pc_o[1]=IBF_B; pc_o[0]=INTR_B; these bits are forced to oe=0/1/1.
REQ-029 STB SHALL be sampled every clk; a falling edge (prev 1, now 0) SHALL latch pa_i/pb_i into the input latch and set IBF.
REQ-030 A rising edge of STB with IBF=1 and INTE=1 SHALL set INTR.
REQ-031 INTE_A SHALL equal the last bit-set/reset value written to PC4 and INTE_B the last written to PC2; these do not drive pins.
REQ-032 Reads of PA/PB in mode 1 SHALL return the input latch, and a read cycle (cs & rnw at edge) SHALL clear IBF and INTR.
REQ-033 If a read-clear and a STB falling edge occur at the same edge, the new latch and IBF=1 SHALL win.
REQ-034 If a control-word write and a STB edge occur at the same edge, the control write SHALL win and flags clear.
REQ-035 Exit from mode 1 SHALL clear that group's IBF, INTR and INTE.

Verification
REQ-036 The bench SHALL cover: reset, read addr 0 with pa_i=8'h5A -> dout=8'h5A, pa_oe=00, pb_oe=00, pc_oe=00.
REQ-037 The bench SHALL cover: write cw 8'h8A then PA=8'h3C -> pa_oe=FF, pa_o=3C; read PA -> 3C; pc_oe=0F.
REQ-038 The bench SHALL cover: write addr 3 8'h07 then 8'h06 -> pc_o[3] goes 1 then 0; cw unchanged.
REQ-039 The bench SHALL cover, with macro: cw 8'hB0, BSR 8'h09, pa_i=A5, pulse STB_A_n low 3 clks -> IBF_A=1, INTR_A=1, irq=1; read PA -> A5, IBF_A=0, irq=0.
REQ-040 The bench SHALL cover, with macro: STB_B_n falls on the same edge as a PB read -> IBF_B stays 1 with the new data.
REQ-041 The bench SHALL cover: reset_n pulsed low with IBF_A=1 -> IBF_A=0 asynchronously, cw=9B.

Source files
------------

// File: rtl/pia8255_gen.sv
// pia8255_gen: 8255-style parallel interface, mode 0 with optional strobed-input mode 1.
// Define PIA_MODE1_EN to enable the mode 1 strobed-input handshake on groups A and B.
module pia8255_gen #(
    parameter logic [7:0] RESET_CW = 8'h9B,
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs,
    input  logic       rnw,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] pa_i,
    input  logic [7:0] pb_i,
    input  logic [7:0] pc_i,
    output logic [7:0] pa_o,
    output logic [7:0] pb_o,
    output logic [7:0] pc_o,
    output logic [7:0] pa_oe,
    output logic [7:0] pb_oe,
    output logic [7:0] pc_oe,
    output logic       irq
);
    logic [7:0] cw, pa_lat, pb_lat, pc_lat, lat_a, lat_b;
    logic ibf_a, ibf_b, intr_a, intr_b, inte_a, inte_b, stb_a_q, stb_b_q;
    logic mode_a, mode_b, wr, rd, cw_wr, bsr_wr;
    logic fall_a, rise_a, rd_a, fall_b, rise_b, rd_b;

`ifdef PIA_MODE1_EN
    assign mode_a = (cw[6:5] == 2'b01) & cw[4];
    assign mode_b = cw[2] & cw[1];
`else
    logic unused_cw;
    assign mode_a = 1'b0;
    assign mode_b = 1'b0;
    assign unused_cw = ^{cw[6:5], cw[2]};
`endif

    assign wr     = cs & ~rnw;
    assign rd     = cs & rnw;
    assign cw_wr  = wr & (addr == 2'd3) & din[7];
    assign bsr_wr = wr & (addr == 2'd3) & ~din[7];
    assign fall_a = mode_a & stb_a_q & ~pc_i[4];
    assign rise_a = mode_a & ~stb_a_q & pc_i[4];
    assign rd_a   = mode_a & rd & (addr == 2'd0);
    assign fall_b = mode_b & stb_b_q & ~pc_i[2];
    assign rise_b = mode_b & ~stb_b_q & pc_i[2];
    assign rd_b   = mode_b & rd & (addr == 2'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cw      <= RESET_CW;
            pa_lat  <= 8'h00;
            pb_lat  <= 8'h00;
            pc_lat  <= PC_RESET;
            lat_a   <= 8'h00;
            lat_b   <= 8'h00;
            {ibf_a, intr_a, inte_a} <= 3'b000;
            {ibf_b, intr_b, inte_b} <= 3'b000;
            stb_a_q <= 1'b1;
            stb_b_q <= 1'b1;
        end else begin
            stb_a_q <= pc_i[4];
            stb_b_q <= pc_i[2];
            if (wr && addr == 2'd0) pa_lat <= din;
            if (wr && addr == 2'd1) pb_lat <= din;
            if (wr && addr == 2'd2) pc_lat <= din;
            if (bsr_wr) pc_lat[din[3:1]] <= din[0];
            if (cw_wr) begin
                cw     <= din;
                pa_lat <= 8'h00;
                pb_lat <= 8'h00;
                pc_lat <= 8'h00;
            end
            // a strobe landing on a read-clear edge keeps the new data pending
            if (fall_a) lat_a <= pa_i;
            ibf_a  <= fall_a | (ibf_a & ~rd_a);
            intr_a <= ~rd_a & (intr_a | (rise_a & ibf_a & inte_a));
            if (bsr_wr && din[3:1] == 3'd4) inte_a <= din[0];
            if (cw_wr || !mode_a) {ibf_a, intr_a, inte_a} <= 3'b000;
            if (fall_b) lat_b <= pb_i;
            ibf_b  <= fall_b | (ibf_b & ~rd_b);
            intr_b <= ~rd_b & (intr_b | (rise_b & ibf_b & inte_b));
            if (bsr_wr && din[3:1] == 3'd2) inte_b <= din[0];
            if (cw_wr || !mode_b) {ibf_b, intr_b, inte_b} <= 3'b000;
        end
    end

    assign pa_o  = pa_lat;
    assign pb_o  = pb_lat;
    assign pa_oe = {8{~cw[4]}};
    assign pb_oe = {8{~cw[1]}};
    assign irq   = intr_a | intr_b;

    // handshake pins override the PC latch and nibble direction in mode 1
    always_comb begin
        pc_o  = pc_lat;
        pc_oe = {{4{~cw[3]}}, {4{~cw[0]}}};
        if (mode_a) begin
            pc_o[5]     = ibf_a;
            pc_o[3]     = intr_a;
            pc_oe[5:3]  = 3'b101;
        end
        if (mode_b) begin
            pc_o[1:0]   = {ibf_b, intr_b};
            pc_oe[2:0]  = 3'b011;
        end
    end

    assign dout = (addr == 2'd0) ? (mode_a ? lat_a : (pa_lat & pa_oe) | (pa_i & ~pa_oe)) :
                  (addr == 2'd1) ? (mode_b ? lat_b : (pb_lat & pb_oe) | (pb_i & ~pb_oe)) :
                  (addr == 2'd2) ? (pc_o & pc_oe) | (pc_i & ~pc_oe) : 8'h00;
endmodule
